fifo_unpacker: RTL and testbench

- Read-side consumer for the team's dual-clock FIFO. Runs entirely in the FIFO's read clock domain.
- Pops DWIDTH-bit words from the FIFO read port, which is first-word-fall-through: data is valid whenever empty is low, and a read pops on the clock edge.
- Serialises each word into OWIDTH-bit beats on a valid/ready stream, for byte-oriented sinks such as a UART TX or SPI shifter.
- Marks the final beat of each word and counts words consumed.

---
 rtl/fifo_unpacker_pkg.sv | 13 +
 rtl/fifo_unpacker.sv | 100 ++++++++++
 tb/tb_fifo_unpacker.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_unpacker_pkg.sv
// Shared types and helpers for the FIFO read-side word-to-beat unpacker.
package fifo_unpacker_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    function automatic int beat_count(input int dwidth, input int owidth);
        return dwidth / owidth;
    endfunction

endpackage

// File: rtl/fifo_unpacker.sv
// Pops words from a first-word-fall-through FIFO and streams them out as
// OWIDTH-bit beats on a valid/ready interface, flagging the last beat of each word.
module fifo_unpacker
    import fifo_unpacker_pkg::*;
#(
    parameter int DWIDTH    = 32,
    parameter int OWIDTH    = 8,
    parameter int MSB_FIRST = 0,
    parameter int CWIDTH    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              fifo_empty_i,
    input  logic [DWIDTH-1:0] fifo_data_i,
    output logic              fifo_read_o,
    output logic [OWIDTH-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              out_last_o,
    output logic [CWIDTH-1:0] words_o
);

    localparam int BEATS  = beat_count(DWIDTH, OWIDTH);
    localparam int IWIDTH = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IWIDTH-1:0] LAST_IDX = IWIDTH'(BEATS - 1);

    if (((DWIDTH % OWIDTH) != 0) || (BEATS < 2)) begin : g_param_check
        $error("fifo_unpacker: DWIDTH must be a multiple of OWIDTH giving at least two beats");
    end

    state_t              state_q, state_d;
    logic [DWIDTH-1:0]   shift_q, shift_d;
    logic [IWIDTH-1:0]   index_q, index_d;
    logic [CWIDTH-1:0]   words_q, words_d;
    logic                handshake;
    logic                at_last;
    logic                pop;

    assign handshake = (state_q == HOLD) && out_ready_i;
    assign at_last   = (index_q == LAST_IDX);
    // No pop may leak out while reset holds the FSM in EMPTY.
    assign pop       = !rst_i && !fifo_empty_i &&
                       ((state_q == EMPTY) || (handshake && at_last));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            shift_q <= '0;
            index_q <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            index_q <= index_d;
            words_q <= words_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (!fifo_empty_i) state_d = HOLD;
            HOLD:    if (handshake && at_last && fifo_empty_i) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // A pop reloads the register; otherwise only an accepted non-final beat advances it.
    always_comb begin
        shift_d = shift_q;
        index_d = index_q;
        words_d = words_q;
        if (pop) begin
            shift_d = fifo_data_i;
            index_d = '0;
            words_d = words_q + CWIDTH'(1);
        end else if (handshake && !at_last) begin
            if (MSB_FIRST != 0) begin
                shift_d = shift_q << OWIDTH;
            end else begin
                shift_d = shift_q >> OWIDTH;
            end
            index_d = index_q + IWIDTH'(1);
        end
    end

    always_comb begin
        out_valid_o = (state_q == HOLD);
        out_last_o  = (state_q == HOLD) && at_last;
        fifo_read_o = pop;
        if (MSB_FIRST != 0) begin
            out_data_o = shift_q[DWIDTH-1 -: OWIDTH];
        end else begin
            out_data_o = shift_q[OWIDTH-1:0];
        end
    end

    assign words_o = words_q;

endmodule

// File: tb/tb_fifo_unpacker.sv
// Self-checking bench: an LSB-first/16-bit-count and an MSB-first/4-bit-count unpacker
// share one modelled FIFO and sink, checked every cycle against a beat-count model.
module tb_fifo_unpacker;

    localparam int DW    = 32;
    localparam int OW    = 8;
    localparam int BEATS = DW / OW;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          ready;

    logic          a_read, a_valid, a_last;
    logic [OW-1:0] a_data;
    logic [15:0]   a_words;
    logic          b_read, b_valid, b_last;
    logic [OW-1:0] b_data;
    logic [3:0]    b_words;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] fifoq[$];
    logic [DW-1:0] cur_word = '0;
    int            held = 0;
    int            pops = 0;
    logic [DW-1:0] acc_a = '0;
    logic [DW-1:0] acc_b = '0;

    always #5 clk = ~clk;

    fifo_unpacker #(.DWIDTH(DW), .OWIDTH(OW), .MSB_FIRST(0), .CWIDTH(16)) dut_lsb (
        .clk_i(clk), .rst_i(rst), .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_data),
        .fifo_read_o(a_read), .out_data_o(a_data), .out_valid_o(a_valid),
        .out_ready_i(ready), .out_last_o(a_last), .words_o(a_words)
    );

    fifo_unpacker #(.DWIDTH(DW), .OWIDTH(OW), .MSB_FIRST(1), .CWIDTH(4)) dut_msb (
        .clk_i(clk), .rst_i(rst), .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_data),
        .fifo_read_o(b_read), .out_data_o(b_data), .out_valid_o(b_valid),
        .out_ready_i(ready), .out_last_o(b_last), .words_o(b_words)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive the FIFO/sink, check both DUTs mid-cycle, then advance the model.
    task automatic applyStimulus(input logic rdy);
        logic          hs;
        logic          exp_read;
        logic [DW-1:0] lane;
        ready      = rdy;
        fifo_empty = (fifoq.size() == 0);
        fifo_data  = fifo_empty ? '0 : fifoq[0];
        @(negedge clk);
        hs       = (held > 0) && rdy;
        exp_read = !fifo_empty && ((held == 0) || (hs && held == 1));
        checkOutput("valid_lsb", a_valid, held > 0);
        checkOutput("valid_msb", b_valid, held > 0);
        checkOutput("read_lsb", a_read, exp_read);
        checkOutput("read_msb", b_read, exp_read);
        if (held > 0) begin
            lane = cur_word >> (OW * (BEATS - held));
            checkOutput("data_lsb", a_data, lane[OW-1:0]);
            lane = cur_word >> (OW * (held - 1));
            checkOutput("data_msb", b_data, lane[OW-1:0]);
        end
        checkOutput("last_lsb", a_last, held == 1);
        checkOutput("last_msb", b_last, held == 1);
        checkOutput("words_lsb", a_words, pops % 65536);
        checkOutput("words_msb", b_words, pops % 16);
        if (hs) begin
            acc_a = {a_data, acc_a[DW-1:OW]};
            acc_b = {acc_b[DW-OW-1:0], b_data};
        end
        @(posedge clk);
        #1;
        if (hs) held--;
        if (exp_read) begin
            cur_word = fifoq.pop_front();
            held     = BEATS;
            pops++;
        end
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        #1;
        checkOutput("rst_valid", a_valid, 0);
        checkOutput("rst_words", a_words, 0);
        checkOutput("rst_words_msb", b_words, 0);
        checkOutput("rst_read", a_read, 0);
        checkOutput("rst_last", a_last, 0);
        repeat (2) begin
            @(negedge clk);
            checkOutput("rst_read_hold", a_read, 0);
            checkOutput("rst_read_hold_msb", b_read, 0);
        end
        @(posedge clk);
        #1;
        rst  = 1'b0;
        held = 0;
        pops = 0;
    endtask

    task automatic drain();
        int guard = 0;
        while ((fifoq.size() != 0 || held != 0) && guard < 400) begin
            applyStimulus(1'b1);
            guard++;
        end
        checkOutput("drain_done", (fifoq.size() == 0 && held == 0), 1);
    endtask

    initial begin
        rst        = 1'b1;
        fifo_empty = 1'b1;
        fifo_data  = '0;
        ready      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_valid", a_valid, 0);
        checkOutput("reset_last", a_last, 0);
        checkOutput("reset_data", a_data, 0);
        checkOutput("reset_data_msb", b_data, 0);
        checkOutput("reset_read", a_read, 0);
        checkOutput("reset_words", a_words, 0);
        rst = 1'b0;

        // Single word, both beat orders
        fifoq.push_back(32'h44332211);
        acc_a = '0; acc_b = '0;
        repeat (6) applyStimulus(1'b1);
        checkOutput("order_lsb", acc_a, 32'h44332211);
        checkOutput("order_msb", acc_b, 32'h44332211);
        checkOutput("one_word", a_words, 1);

        // Back-to-back words and then a late arrival after the FIFO runs dry
        fifoq.push_back(32'hA3A2A1A0);
        fifoq.push_back(32'hB3B2B1B0);
        repeat (10) applyStimulus(1'b1);
        repeat (3) applyStimulus(1'b1);
        fifoq.push_back(32'hC3C2C1C0);
        drain();

        // Sink stalls for three cycles on the second beat
        fifoq.push_back(32'h44332211);
        fifoq.push_back(32'h88776655);
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        checkOutput("stall_beat", a_data, 8'h22);
        repeat (3) applyStimulus(1'b0);
        drain();

        // Reset while the third beat is held
        fifoq.push_back(32'h44332211);
        fifoq.push_back(32'h55667788);
        while (held != 2) applyStimulus(1'b1);
        checkOutput("pre_rst_beat", a_data, 8'h33);
        fifo_empty = 1'b0;
        fifo_data  = fifoq[0];
        pulseReset();
        acc_a = '0;
        repeat (5) applyStimulus(1'b1);
        checkOutput("post_rst_word", acc_a, 32'h55667788);
        drain();

        // Randomised traffic and backpressure
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0 && fifoq.size() < 8) fifoq.push_back($urandom);
            applyStimulus($urandom_range(0, 3) != 0);
        end
        drain();

        // Counter wrap on the 4-bit instance
        pulseReset();
        for (int i = 0; i < 17; i++) fifoq.push_back($urandom);
        drain();
        checkOutput("wrap17_msb", b_words, 1);
        checkOutput("count17_lsb", a_words, 17);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
